tag_check_scheduler: RTL and testbench
======================================

// Module: tag_check_scheduler
// PURPOSE
//  Shares one combinational tag_generation datapath between NUM_REQ requesters.
//  Each request is either GENERATE (return the tag for a data word) or CHECK (compare the
//  generated tag against a supplied tag). Grants are round-robin; one response is produced per request.
//  Also keeps a saturating mismatch count and raises a sticky alarm at a set threshold.
//  Sits between the load/store tag ports and the single tag_generation instance.
// PARAMETERS
//  DATA_SIZE       32  width of the data word fed to tag_generation
//  TAG_SIZE        8   width of the tag
//  NUM_REQ         4   number of requesters (>=2); ID_W = $clog2(NUM_REQ)
//  MISMATCH_LIMIT  8   mismatch count at which alarm asserts (1..65535)
// PORTS
//  clk        in   1                   clock, rising edge
//  reset      in   1                   asynchronous, active-high reset
//  req_valid  in   NUM_REQ             per-requester request valid
//  req_op     in   NUM_REQ             per-requester op: 0=GENERATE, 1=CHECK
//  req_data   in   NUM_REQ*DATA_SIZE   requester i data at [i*DATA_SIZE +: DATA_SIZE]
//  req_tag    in   NUM_REQ*TAG_SIZE    requester i expected tag (CHECK only)
//  req_ready  out  NUM_REQ             one-hot grant; request accepted when valid&ready
//  tg_data    out  DATA_SIZE           data driven to the shared tag_generation unit
//  tg_tag     in   TAG_SIZE            tag returned by tag_generation (combinational)
//  rsp_valid  out  1                   response valid
//  rsp_ready  in   1                   response consumer ready
//  rsp_id     out  ID_W                index of the requester being answered
//  rsp_tag    out  TAG_SIZE            generated tag
//  rsp_ok     out  1                   GENERATE: 1; CHECK: 1 if tags match
//  mismatch_cnt out 16                 count of failed CHECK responses, saturates at 16'hFFFF
//  alarm      out  1                   sticky; set when mismatch_cnt reaches MISMATCH_LIMIT
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, req_ready=0, tg_data=0, rsp_valid=0,
//   rsp_id=0, rsp_tag=0, rsp_ok=0, mismatch_cnt=0, alarm=0. Any in-flight request is dropped; it gets no response.
//  FSM: IDLE -> GEN -> RESP -> IDLE.
//   IDLE: if alarm=0 and any req_valid, grant the first valid index at or after rr_ptr
//         (wrapping modulo NUM_REQ). req_ready[g] is asserted combinationally that cycle only.
//         Latch op, data, tag and id=g; set rr_ptr=(g+1)%NUM_REQ; go to GEN.
//         If nothing is valid or alarm=1: stay in IDLE with req_ready=0.
//   GEN:  tg_data = latched data (held from GEN through RESP). At the clock edge, capture
//         rsp_tag=tg_tag and rsp_ok=(op==GENERATE) | (tg_tag==latched tag); go to RESP.
//   RESP: rsp_valid=1. rsp_id, rsp_tag and rsp_ok stay stable until rsp_valid&rsp_ready.
//         On that handshake: go to IDLE, rsp_valid=0. If the op was CHECK and rsp_ok=0,
//         increment mismatch_cnt (saturating).
//  Latency: grant in cycle T -> rsp_valid high in cycle T+2. Best throughput is 1 request per 3 cycles.
//  req_ready is never asserted outside IDLE, and is never asserted for a requester with valid=0.
//   A requester may drop valid before it is granted; this has no effect.
//  alarm: set in the same cycle mismatch_cnt becomes >= MISMATCH_LIMIT. Cleared only by reset.
//   A response already in RESP when alarm sets still completes normally.
//  Simultaneous requests resolve purely by rr_ptr; no requester waits more than NUM_REQ-1 grants.
// TESTING (bench stub: tg_tag = tg_data[7:0] ^ 8'h5A)
//  1 GENERATE from req 1, data=32'h0000_0033, only valid -> req_ready=4'b0010 at T;
//    rsp_valid at T+2 with rsp_id=1, rsp_tag=8'h69, rsp_ok=1.
//  2 All 4 req_valid held high continuously, rsp_ready=1 -> grant order 0,1,2,3,0,
//    with grants 3 cycles apart.
//  3 CHECK req 2, data=32'h11, req_tag=8'h4B -> rsp_ok=1, mismatch_cnt stays 0;
//    same with req_tag=8'h00 -> rsp_ok=0, mismatch_cnt=1 after the handshake.
//  4 rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0 throughout;
//    rsp_ready=1 -> next grant is 1 cycle later.
//  5 MISMATCH_LIMIT=2, two failed CHECKs -> alarm=1 after the 2nd handshake;
//    further req_valid gets no req_ready for 20 cycles.
//  6 reset pulsed while in GEN and while in RESP -> all outputs return to reset values
//    immediately; no response follows.

Source files
------------

// File: rtl/tag_check_scheduler.sv
// tag_check_scheduler
// Time-shares one combinational tag_generation unit between NUM_REQ requesters.
// Each accepted request is either GENERATE (return the tag of a data word) or
// CHECK (also compare that tag against a supplied one). Requesters are granted
// round-robin. Each request passes through IDLE -> GEN -> RESP and produces exactly
// one response. Failed CHECK responses are counted in a saturating counter. A sticky
// alarm stops further grants once that count reaches MISMATCH_LIMIT.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   req_valid      per-requester request valid
//   req_op         per-requester op (0 = GENERATE, 1 = CHECK)
//   req_data       requester i data word at [i*DATA_SIZE +: DATA_SIZE]
//   req_tag        requester i expected tag at [i*TAG_SIZE +: TAG_SIZE]
//   req_ready      one-hot grant, asserted only in the grant cycle
//   tg_data        data word presented to the shared tag_generation unit
//   tg_tag         tag returned combinationally by tag_generation
//   rsp_valid      response valid; rsp_ready is the consumer handshake
//   rsp_id         index of the requester being answered
//   rsp_tag        generated tag
//   rsp_ok         1 for GENERATE, tag-match result for CHECK
//   mismatch_cnt   number of failed CHECK responses, saturating at 16'hFFFF
//   alarm          sticky, set when mismatch_cnt reaches MISMATCH_LIMIT
module tag_check_scheduler #(
    parameter int DATA_SIZE      = 32,
    parameter int TAG_SIZE       = 8,
    parameter int NUM_REQ        = 4,
    parameter int MISMATCH_LIMIT = 8,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
    input  logic [NUM_REQ*TAG_SIZE-1:0]   req_tag,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_SIZE-1:0]          tg_data,
    input  logic [TAG_SIZE-1:0]           tg_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [TAG_SIZE-1:0]           rsp_tag,
    output logic                          rsp_ok,
    output logic [15:0]                   mismatch_cnt,
    output logic                          alarm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [ID_W-1:0]        rr_ptr_r;
    logic                   grant_found_s;
    logic [ID_W-1:0]        grant_idx_s;
    logic                   accept_s;
    logic                   handshake_s;
    logic                   op_r;
    logic [DATA_SIZE-1:0]   data_r;
    logic [TAG_SIZE-1:0]    tag_r;
    logic [ID_W-1:0]        id_r;
    logic                   rsp_valid_r;
    logic [TAG_SIZE-1:0]    rsp_tag_r;
    logic                   rsp_ok_r;
    logic [15:0]            mismatch_cnt_r;
    logic [15:0]            mismatch_next_s;
    logic                   alarm_r;

    // Requester index base+offset, wrapped modulo NUM_REQ (offset < NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NUM_REQ) ? ID_W'(sum - NUM_REQ) : ID_W'(sum);
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && req_valid[wrap_idx(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = wrap_idx(rr_ptr_r, k);
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // A grant only happens from IDLE while the alarm is clear.
    assign accept_s    = (state_r == ST_IDLE) && !alarm_r && grant_found_s;
    assign handshake_s = (state_r == ST_RESP) && rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_GEN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GEN:  state_next_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the one-hot grant is combinational, but held low during reset.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (accept_s && !reset) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Mismatch count after a possible failed-CHECK handshake this cycle, saturating.
    always_comb begin
        mismatch_next_s = mismatch_cnt_r;
        if (handshake_s && op_r && !rsp_ok_r && (mismatch_cnt_r != 16'hFFFF)) begin
            mismatch_next_s = mismatch_cnt_r + 16'd1;
        end else begin
            mismatch_next_s = mismatch_cnt_r;
        end
    end

    // Request capture at grant time and round-robin pointer update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r     <= 1'b0;
            data_r   <= {DATA_SIZE{1'b0}};
            tag_r    <= {TAG_SIZE{1'b0}};
            id_r     <= {ID_W{1'b0}};
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (accept_s) begin
            op_r     <= req_op[grant_idx_s];
            data_r   <= req_data[int'(grant_idx_s)*DATA_SIZE +: DATA_SIZE];
            tag_r    <= req_tag[int'(grant_idx_s)*TAG_SIZE +: TAG_SIZE];
            id_r     <= grant_idx_s;
            rr_ptr_r <= wrap_idx(grant_idx_s, 1);
        end else begin
            op_r     <= op_r;
        end
    end

    // Response registers: result captured in GEN, valid held until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_tag_r   <= {TAG_SIZE{1'b0}};
            rsp_ok_r    <= 1'b0;
        end else if (state_r == ST_GEN) begin
            rsp_valid_r <= 1'b1;
            rsp_tag_r   <= tg_tag;
            rsp_ok_r    <= !op_r || (tg_tag == tag_r);
        end else if (handshake_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Mismatch counter and sticky alarm; the alarm rises with the count that reaches the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_cnt_r <= 16'd0;
            alarm_r        <= 1'b0;
        end else begin
            mismatch_cnt_r <= mismatch_next_s;
            alarm_r        <= alarm_r || (mismatch_next_s >= 16'(MISMATCH_LIMIT));
        end
    end

    assign tg_data      = data_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_id       = id_r;
    assign rsp_tag      = rsp_tag_r;
    assign rsp_ok       = rsp_ok_r;
    assign mismatch_cnt = mismatch_cnt_r;
    assign alarm        = alarm_r;

endmodule

// File: tb/tb_tag_check_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for tag_check_scheduler. The bench stubs the tag generator as
// tg_tag = tg_data[7:0] ^ 8'h5A. A second instance with MISMATCH_LIMIT=2 shares all
// inputs and is used for the alarm scenario.
module tb_tag_check_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_op, req_ready, req_ready2;
    logic [127:0] req_data;
    logic [31:0]  req_tag;
    logic [31:0]  tg_data, tg_data2;
    logic [7:0]   tg_tag, tg_tag2, rsp_tag, rsp_tag2;
    logic         rsp_valid, rsp_valid2, rsp_ready, rsp_ok, rsp_ok2, alarm, alarm2;
    logic [1:0]   rsp_id, rsp_id2;
    logic [15:0]  mismatch_cnt, mismatch_cnt2;
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    assign tg_tag  = tg_data[7:0] ^ 8'h5A;
    assign tg_tag2 = tg_data2[7:0] ^ 8'h5A;

    tag_check_scheduler #(.DATA_SIZE(32), .TAG_SIZE(8), .NUM_REQ(4), .MISMATCH_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready), .tg_data(tg_data), .tg_tag(tg_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_ok(rsp_ok), .mismatch_cnt(mismatch_cnt), .alarm(alarm));

    tag_check_scheduler #(.DATA_SIZE(32), .TAG_SIZE(8), .NUM_REQ(4), .MISMATCH_LIMIT(2)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
        .req_tag(req_tag), .req_ready(req_ready2), .tg_data(tg_data2), .tg_tag(tg_tag2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_tag(rsp_tag2),
        .rsp_ok(rsp_ok2), .mismatch_cnt(mismatch_cnt2), .alarm(alarm2));

    task automatic set_req(input int i, input logic op, input logic [31:0] d, input logic [7:0] t);
        req_op[i] = op;
        req_data[i*32 +: 32] = d;
        req_tag[i*8 +: 8] = t;
    endtask

    // Reset both instances; returns just after a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 4'd0; req_op = 4'd0; req_data = 128'd0; req_tag = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one request from requester i and consume its response (bounded waits).
    task automatic run_txn(input int i, input logic op, input logic [31:0] d, input logic [7:0] t,
                           output logic done, output logic [1:0] id, output logic [7:0] tag,
                           output logic ok);
        logic granted;
        granted = 1'b0; done = 1'b0; id = 2'd0; tag = 8'd0; ok = 1'b0;
        @(posedge clk); #1;
        set_req(i, op, d, t);
        req_valid[i] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin granted = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (granted) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (rsp_valid) begin done = 1'b1; id = rsp_id; tag = rsp_tag; ok = rsp_ok; break; end
                @(posedge clk); #1;
            end
            if (done) begin
                rsp_ready = 1'b1;
                @(posedge clk); #1 rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'hF; req_op = 4'd0; req_data = {4{32'hCAFE_F00D}};
        req_tag = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        req_valid = 4'd0;
    endtask

    task automatic test_generate();
        do_reset();
        set_req(1, 1'b0, 32'h0000_0033, 8'h00);
        req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL gen_grant: got %b want 0010", req_ready); end
        @(posedge clk); #1 req_valid = 4'd0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, req_ready, tg_data} !== {1'b0, 4'd0, 32'h33}) begin
            n_fail++; $display("FAIL gen_t1: got %h want %h", {rsp_valid, req_ready, tg_data}, {1'b0, 4'd0, 32'h33});
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_tag, rsp_ok} !== {1'b1, 2'd1, 8'h69, 1'b1}) begin
            n_fail++; $display("FAIL gen_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_tag, rsp_ok},
                               {1'b1, 2'd1, 8'h69, 1'b1});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, mismatch_cnt} !== 17'd0) begin
            n_fail++; $display("FAIL gen_done: got %h want 0", {rsp_valid, mismatch_cnt});
        end
    endtask

    task automatic test_round_robin();
        int ng, nr, last, cyc;
        ng = 0; nr = 0; last = 0; cyc = 0;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, $urandom, 8'h00);
        req_valid = 4'hF; rsp_ready = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (req_ready !== 4'd0) begin
                n_cmp++;
                if (req_ready !== (4'b0001 << (ng % 4))) begin
                    n_fail++; $display("FAIL rr_order: got %b want %b", req_ready, 4'b0001 << (ng % 4));
                end
                if (ng > 0) begin
                    n_cmp++;
                    if (cyc - last !== 3) begin n_fail++; $display("FAIL rr_spacing: got %0d want 3", cyc - last); end
                end
                last = cyc; ng++;
            end
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_id !== 2'(nr % 4)) begin n_fail++; $display("FAIL rr_rsp_id: got %0d want %0d", rsp_id, nr % 4); end
                nr++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (ng < 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d want >=5", ng); end
        req_valid = 4'd0; rsp_ready = 1'b0;
    endtask

    task automatic test_check();
        logic done, ok;
        logic [1:0] id;
        logic [7:0] tag;
        do_reset();
        run_txn(2, 1'b1, 32'h11, 8'h4B, done, id, tag, ok);
        @(negedge clk);
        n_cmp++;
        if ({done, id, tag, ok, mismatch_cnt} !== {1'b1, 2'd2, 8'h4B, 1'b1, 16'd0}) begin
            n_fail++; $display("FAIL check_match: got %h want %h", {done, id, tag, ok, mismatch_cnt},
                               {1'b1, 2'd2, 8'h4B, 1'b1, 16'd0});
        end
        run_txn(2, 1'b1, 32'h11, 8'h00, done, id, tag, ok);
        @(negedge clk);
        n_cmp++;
        if ({done, id, tag, ok, mismatch_cnt, alarm} !== {1'b1, 2'd2, 8'h4B, 1'b0, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL check_mismatch: got %h want %h", {done, id, tag, ok, mismatch_cnt, alarm},
                               {1'b1, 2'd2, 8'h4B, 1'b0, 16'd1, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] etag;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, $urandom, 8'h00);
        etag = req_data[7:0] ^ 8'h5A;
        req_valid = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_id, rsp_tag, rsp_ok, req_ready} !== {1'b1, 2'd0, etag, 1'b1, 4'd0}) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got %h want %h", c,
                                   {rsp_valid, rsp_id, rsp_tag, rsp_ok, req_ready}, {1'b1, 2'd0, etag, 1'b1, 4'd0});
            end
            if (c < 5) begin @(posedge clk); #1; end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid} !== {4'b0010, 1'b0}) begin
            n_fail++; $display("FAIL bp_next_grant: got %b want 00100", {req_ready, rsp_valid});
        end
        req_valid = 4'd0;
    endtask

    task automatic test_alarm();
        logic done, ok;
        logic [1:0] id;
        logic [7:0] tag;
        do_reset();
        run_txn(0, 1'b1, 32'h0000_00A5, 8'h00, done, id, tag, ok);
        @(negedge clk);
        n_cmp++;
        if ({done, mismatch_cnt2, alarm2} !== {1'b1, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL alarm_first: got %h want %h", {done, mismatch_cnt2, alarm2}, {1'b1, 16'd1, 1'b0});
        end
        run_txn(3, 1'b1, 32'h0000_1234, 8'h00, done, id, tag, ok);
        @(negedge clk);
        n_cmp++;
        if ({done, mismatch_cnt2, alarm2, alarm} !== {1'b1, 16'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL alarm_set: got %h want %h", {done, mismatch_cnt2, alarm2, alarm},
                               {1'b1, 16'd2, 1'b1, 1'b0});
        end
        req_valid = 4'hF;
        repeat (20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({req_ready2, rsp_valid2, alarm2} !== {4'd0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL alarm_block: got %b want 000001", {req_ready2, rsp_valid2, alarm2});
            end
        end
        req_valid = 4'd0;
    endtask

    task automatic test_reset_inflight();
        logic done, ok;
        logic [1:0] id;
        logic [7:0] tag;
        do_reset();
        run_txn(0, 1'b1, 32'h0000_00C3, 8'h00, done, id, tag, ok);
        // Abort in GEN.
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'hDEAD_BEEF, 8'h00);
        req_valid = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, mismatch_cnt} !== {4'b0010, 16'd1}) begin
            n_fail++; $display("FAIL rst_gen_pre: got %h want %h", {req_ready, mismatch_cnt}, {4'b0010, 16'd1});
        end
        @(posedge clk); #1 req_valid = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm} !== 64'd0) begin
            n_fail++; $display("FAIL rst_gen: got %h want 0",
                               {req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm});
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, req_ready} !== 5'd0) begin n_fail++; $display("FAIL rst_gen_quiet: got %b want 0", {rsp_valid, req_ready}); end
            @(posedge clk); #1;
        end
        // Abort in RESP.
        set_req(2, 1'b0, 32'h0000_0033, 8'h00);
        req_valid = 4'b0100;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 4'd0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_tag} !== {1'b1, 2'd2, 8'h69}) begin
            n_fail++; $display("FAIL rst_resp_pre: got %h want %h", {rsp_valid, rsp_id, rsp_tag}, {1'b1, 2'd2, 8'h69});
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm} !== 64'd0) begin
            n_fail++; $display("FAIL rst_resp: got %h want 0",
                               {req_ready, tg_data, rsp_valid, rsp_id, rsp_tag, rsp_ok, mismatch_cnt, alarm});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_quiet: got %b want 0", rsp_valid); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
    endtask

    // Randomized traffic checked against a transaction-level model of the scheduler.
    task automatic test_random();
        int rr, gcyc, m_cnt, g;
        bit busy, m_alarm, e_op, e_ok, exp_v;
        logic [1:0] e_id;
        logic [7:0] e_tag;
        logic [3:0] exp_ready;
        logic [31:0] d;
        rr = 0; gcyc = 0; m_cnt = 0; busy = 1'b0; m_alarm = 1'b0; e_op = 1'b0; e_ok = 1'b0;
        e_id = 2'd0; e_tag = 8'd0;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom_range(15));
            rsp_ready = 1'($urandom_range(1));
            for (int i = 0; i < 4; i++) begin
                d = $urandom;
                set_req(i, 1'($urandom_range(1)), d, ($urandom_range(7) == 0) ? 8'($urandom) : (d[7:0] ^ 8'h5A));
            end
            @(negedge clk);
            n_cmp++;
            if ({mismatch_cnt, alarm} !== {16'(m_cnt), m_alarm}) begin
                n_fail++; $display("FAIL rnd_count: cycle %0d got %0d/%b want %0d/%b", cyc, mismatch_cnt, alarm, m_cnt, m_alarm);
            end
            g = -1;
            if (!busy && !m_alarm) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req_valid[(rr + k) % 4]) g = (rr + k) % 4;
                end
            end
            exp_ready = (g >= 0) ? (4'b0001 << g) : 4'd0;
            n_cmp++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_grant: cycle %0d got %b want %b", cyc, req_ready, exp_ready);
            end
            if (g >= 0) begin
                busy = 1'b1; gcyc = cyc; e_id = 2'(g); e_op = req_op[g];
                e_tag = req_data[g*32 +: 8] ^ 8'h5A;
                e_ok = !e_op || (req_tag[g*8 +: 8] == e_tag);
                rr = (g + 1) % 4;
            end else if (busy) begin
                exp_v = (cyc >= gcyc + 2);
                n_cmp++;
                if (rsp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rsp_valid: cycle %0d got %b want %b", cyc, rsp_valid, exp_v); end
                if (exp_v) begin
                    n_cmp++;
                    if ({rsp_id, rsp_tag, rsp_ok} !== {e_id, e_tag, e_ok}) begin
                        n_fail++; $display("FAIL rnd_rsp: cycle %0d got %h want %h", cyc, {rsp_id, rsp_tag, rsp_ok}, {e_id, e_tag, e_ok});
                    end
                    if (rsp_ready) begin
                        busy = 1'b0;
                        if (e_op && !e_ok && m_cnt < 65535) m_cnt++;
                        if (m_cnt >= 8) m_alarm = 1'b1;
                    end
                end
            end else begin
                n_cmp++;
                if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle: cycle %0d got rsp_valid=%b want 0", cyc, rsp_valid); end
            end
        end
        req_valid = 4'd0; rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_generate();
        test_round_robin();
        test_check();
        test_backpressure();
        test_alarm();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
